ks_addsub_pipe: RTL and testbench
=================================

KS_ADDSUB_PIPE -- requirements
Module: ks_addsub_pipe

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width, legal range 4..32.
REQ-002 SHALL have parameter STAGES, default 2: pipeline register count, legal range 1..4, equal to the latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 SHALL have port a, input, N bits: operand A, unsigned.
REQ-008 SHALL have port b, input, N bits: operand B, unsigned.
REQ-009 SHALL have port op, input, 2 bits: 00 A+B; 01 A-B; 10 B-A; 11 saturating A-B (clamps at 0).
REQ-010 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port result, output, N bits: the result.
REQ-013 SHALL have port flags, output, 4 bits: {carry_borrow, overflow, zero, negative}.

Function
REQ-014 SHALL compute subtraction as X + ~Y + 1, with the +1 injected as prefix carry-in, never as a pre-incremented operand.
REQ-015 SHALL set carry_borrow to carry-out for op 00 and to NOT carry-out for ops 01/10/11; borrow=1 exactly when minuend < subtrahend (unsigned), including subtrahend = 0 giving borrow 0.
REQ-016 SHALL set overflow to signed two's-complement overflow of the raw (unclamped) operation.
REQ-017 SHALL set zero = (result == 0) and negative = result[N-1], both evaluated on the final (post-clamp) result.
REQ-018 For op 11 SHALL output 0 when borrow=1, else A-B; carry_borrow still reports the raw borrow.
REQ-019 SHALL build the carry network as a Kogge-Stone parallel prefix of ceil(log2 N) levels, with the STAGES registers distributed evenly across those levels; the last register always sits at the output.
REQ-020 Latency: a beat accepted at edge k SHALL appear on result/flags with out_valid=1 after edge k+STAGES, provided no stall occurs.
REQ-021 Handshake: transfer SHALL occur on a cycle where valid & ready; in_valid and in_ready are independent of each other combinationally.
REQ-022 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1.
REQ-023 Bubbles: a stage holding no valid beat SHALL advance even while the pipe is stalled downstream only if a later stage has a free slot; a simple global stall is acceptable provided REQ-022 holds.
REQ-024 result/flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous accept and drain on a full pipe SHALL sustain one beat per cycle with no loss or duplication.
REQ-026 Wrap-around: op 00 with A=B=2^N-1 SHALL give result 2^N-2 and carry 1.

Reset
REQ-027 While rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0, result=0, flags=0.
REQ-028 During reset in_ready SHALL be 0; it SHALL be 1 on the first cycle after rst deasserts.
REQ-029 Beats in flight when rst asserts SHALL be discarded, never emitted.

Structure
REQ-030 A shared package SHALL hold the op encodings (OP_ADD, OP_SUB, OP_RSUB, OP_SUBSAT) and the flag bit indices.
REQ-031 One sub-module, ks_prefix_level, SHALL implement one generate/propagate combine level (parameters N and distance); it is instantiated ceil(log2 N) times.

Verification
REQ-032 N=8, op 01, A=5, B=0 -> result 5, carry_borrow 0, zero 0.
REQ-033 N=8, op 01, A=3, B=5 -> result 0xFE, borrow 1, negative 1; the same operands with op 11 -> result 0, borrow 1, zero 1.
REQ-034 N=8, op 00, A=0x7F, B=0x01 -> result 0x80, overflow 1, carry 0; A=B=0xFF -> result 0xFE, carry 1.
REQ-035 STAGES=2, back-to-back beats 1..10 with out_ready=1 -> first result 2 cycles after its accept; then one result per cycle, in order.
REQ-036 Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0 and result held stable; after release, all beats emerge in order with none lost.
REQ-037 Assert rst with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted, in_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/ks_addsub_pipe_pkg.sv
// Shared definitions for the Kogge-Stone add/subtract pipeline:
// op encodings, flag bit positions and the register placement helper.
package ks_addsub_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_RSUB   = 2'b10,
        OP_SUBSAT = 2'b11
    } op_e;

    localparam int FLAG_C = 3;  // carry (add) or borrow (subtract)
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Prefix level after which pipeline register r sits (r = 0 is the input side).
    function automatic int level_boundary(input int r, input int levels, input int stages);
        return (r * levels) / stages;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone combine level: each bit merges its (g, p) pair with the pair
// DISTANCE bits below it; bits with nothing below pass straight through.
module ks_prefix_level
    import ks_addsub_pipe_pkg::*;
#(
    parameter int N        = 8,
    parameter int DISTANCE = 1
) (
    input  logic [N-1:0] g_in,
    input  logic [N-1:0] p_in,
    output logic [N-1:0] g_out,
    output logic [N-1:0] p_out
);

    for (genvar i = 0; i < N; i++) begin : bit_g
        if (i >= DISTANCE) begin : merge
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DISTANCE]);
            assign p_out[i] = p_in[i] & p_in[i-DISTANCE];
        end else begin : pass
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/ks_addsub_pipe.sv
// Pipelined add/subtract unit on a Kogge-Stone carry network with a
// valid/ready handshake; a global stall freezes every stage while the output waits.
module ks_addsub_pipe
    import ks_addsub_pipe_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int LEVELS = $clog2(N);

    typedef struct packed {
        op_e          op;
        logic         cin;
        logic [N-1:0] hs;  // per-bit half sum x ^ y'
        logic [N-1:0] g;
        logic [N-1:0] p;
    } pipe_t;

    logic              stall;
    logic [STAGES-1:0] vld;
    pipe_t             gen;

    assign out_valid = vld[STAGES-1];
    assign stall     = vld[STAGES-1] & ~out_ready;
    assign in_ready  = ~rst & ~stall;

    // NOTE: every variable driven in always_comb gets a value on all paths (defaults first), so no latch is inferred.
    always_comb begin
        logic [N-1:0] x, y;
        logic         sub;
        x   = a;
        y   = b;
        sub = 1'b1;
        case (op_e'(op))
            OP_ADD:  sub = 1'b0;
            OP_RSUB: begin
                x = b;
                y = a;
            end
            default: ;
        endcase
        gen.op  = op_e'(op);
        gen.cin = sub;
        gen.hs  = x ^ (sub ? ~y : y);
        gen.p   = gen.hs;
        gen.g   = x & (sub ? ~y : y);
        // The +1 of two's-complement subtraction enters as the prefix carry-in.
        gen.g[0] = gen.g[0] | (gen.hs[0] & sub);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            for (int s = 1; s < STAGES; s++) begin
                vld[s] <= vld[s-1];
            end
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : seg
        localparam int LO = level_boundary(s, LEVELS, STAGES);
        localparam int HI = level_boundary(s + 1, LEVELS, STAGES);

        pipe_t        d;
        logic [N-1:0] g_ch [LO:HI];
        logic [N-1:0] p_ch [LO:HI];

        if (s == 0) begin : from_in
            assign d = gen;
        end else begin : from_reg
            assign d = seg[s-1].hold.q;
        end

        assign g_ch[LO] = d.g;
        assign p_ch[LO] = d.p;

        for (genvar k = LO + 1; k <= HI; k++) begin : lvl
            ks_prefix_level #(
                .N        (N),
                .DISTANCE (1 << (k - 1))
            ) u_level (
                .g_in  (g_ch[k-1]),
                .p_in  (p_ch[k-1]),
                .g_out (g_ch[k]),
                .p_out (p_ch[k])
            );
        end

        if (s < STAGES - 1) begin : hold
            pipe_t q;
            // NOTE: datapath registers carry no reset; the valid bits alone decide whether they mean anything.
            always_ff @(posedge clk) begin
                if (!stall) begin
                    q.op  <= d.op;
                    q.cin <= d.cin;
                    q.hs  <= d.hs;
                    q.g   <= g_ch[HI];
                    q.p   <= p_ch[HI];
                end
            end
        end else begin : fin
            logic         cout;
            logic [N-1:0] sum;
            logic [N-1:0] res;
            logic [3:0]   f;
            logic         unused_p;

            assign unused_p = ^p_ch[HI];

            // After the last level g_ch[HI][i] is the carry out of bit i.
            always_comb begin
                cout = g_ch[HI][N-1];
                sum  = d.hs ^ {g_ch[HI][N-2:0], d.cin};
                res  = (d.op == OP_SUBSAT && !cout) ? '0 : sum;
                f         = '0;
                f[FLAG_C] = (d.op == OP_ADD) ? cout : ~cout;
                f[FLAG_V] = cout ^ g_ch[HI][N-2];
                f[FLAG_Z] = (res == '0);
                f[FLAG_N] = res[N-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    result <= '0;
                    flags  <= '0;
                end else if (!stall) begin
                    result <= res;
                    flags  <= f;
                end
            end
        end
    end

endmodule

// File: tb/tb_ks_addsub_pipe.sv
// Self-checking bench for ks_addsub_pipe: arithmetic reference model plus a
// queue scoreboard checked on every cycle the output is valid.
module tb_ks_addsub_pipe;
    import ks_addsub_pipe_pkg::*;

    localparam int N      = 8;
    localparam int STAGES = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [3:0]   flags;

    ks_addsub_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N+3:0] exp;
        int           acc;
        int           stl;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cycle   = 0;
    int    stalls  = 0;
    bit    rst_prev = 1'b0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // {carry_borrow, overflow, zero, negative, result} from plain integer arithmetic.
    function automatic logic [N+3:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic [1:0] o);
        longint       ux, uy, sx, sy, raw, sraw, lim;
        logic         c, v;
        logic [N-1:0] r;
        ux  = longint'(x);
        uy  = longint'(y);
        lim = longint'(1) << N;
        sx  = x[N-1] ? ux - lim : ux;
        sy  = y[N-1] ? uy - lim : uy;
        case (o)
            2'd0: begin raw = ux + uy; sraw = sx + sy; c = (raw >= lim); end
            2'd2: begin raw = uy - ux; sraw = sy - sx; c = (uy < ux); end
            default: begin raw = ux - uy; sraw = sx - sy; c = (ux < uy); end
        endcase
        v = (sraw > (lim / 2) - 1) || (sraw < -(lim / 2));
        r = raw[N-1:0];
        if (o == 2'd3 && c) r = '0;
        return {c, v, (r == '0), r[N-1], r};
    endfunction

    function automatic logic [N-1:0] pick();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(N-1){1'b1}}};
            3: return {1'b1, {(N-1){1'b0}}};
            default: return t[N-1:0];
        endcase
    endfunction

    // Scoreboard / compare process, sampling mid-cycle.
    always @(negedge clk) begin
        bit stall_now;
        cycle++;
        stall_now = out_valid && !out_ready;
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            if (rst_prev) check("rst_outputs", {out_valid, flags, result}, 0);
            q.delete();
        end else begin
            check("in_ready", in_ready, !stall_now);
            if (rst_prev) check("post_rst_out_valid", out_valid, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("data", {flags, result}, q[0].exp);
                    if (out_ready) begin
                        check("latency", cycle - q[0].acc, STAGES + stalls - q[0].stl);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) q.push_back('{model(a, b, op), cycle, stalls});
        end
        if (stall_now) stalls++;
        rst_prev = rst;
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic [1:0] vop);
        bit accepted;
        int t;
        a = va;
        b = vb;
        op = vop;
        in_valid = 1'b1;
        accepted = 1'b0;
        t = 0;
        while (!accepted && t < 200) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!accepted) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed values pin the reference model.
        check("pin_sub_5_0",      model(8'd5,   8'd0,   OP_SUB),    {4'b0000, 8'h05});
        check("pin_sub_3_5",      model(8'd3,   8'd5,   OP_SUB),    {4'b1001, 8'hFE});
        check("pin_subsat_3_5",   model(8'd3,   8'd5,   OP_SUBSAT), {4'b1010, 8'h00});
        check("pin_add_7f_01",    model(8'h7F,  8'h01,  OP_ADD),    {4'b0101, 8'h80});
        check("pin_add_ff_ff",    model(8'hFF,  8'hFF,  OP_ADD),    {4'b1001, 8'hFE});
        check("pin_rsub_3_5",     model(8'd3,   8'd5,   OP_RSUB),   {4'b0000, 8'h02});

        send(8'd5, 8'd0, OP_SUB);
        send(8'd3, 8'd5, OP_SUB);
        send(8'd3, 8'd5, OP_SUBSAT);
        send(8'h7F, 8'h01, OP_ADD);
        send(8'hFF, 8'hFF, OP_ADD);
        send(8'h80, 8'h01, OP_SUB);
        wait_drain();

        // Back-to-back beats 1..10.
        for (int i = 1; i <= 10; i++) send(N'(i), 8'd0, OP_ADD);
        wait_drain();

        // Fill the pipe, stall the output for 5 cycles, then release.
        out_ready = 1'b0;
        send(8'd11, 8'd1, OP_ADD);
        send(8'd12, 8'd1, OP_ADD);
        fork
            send(8'd13, 8'd1, OP_ADD);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        send(8'd14, 8'd1, OP_ADD);
        wait_drain();

        // Reset with two beats in flight: none of them may come out.
        out_ready = 1'b0;
        send(8'd21, 8'd2, OP_SUB);
        send(8'd22, 8'd2, OP_SUB);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(8'd40, 8'd50, OP_RSUB);
        wait_drain();

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(pick(), pick(), 2'($urandom_range(0, 3)));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
